ahb_outstg_rr_arbiter: RTL and testbench

//  Round-robin arbiter for one bus-matrix output stage (shared AHB slave port).

---
 rtl/ahb_outstg_rr_arbiter_pkg.sv | 30 +++
 rtl/ahb_rr_pick.sv | 29 ++
 rtl/ahb_outstg_rr_arbiter.sv | 82 ++++++++
 tb/tb_ahb_outstg_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_outstg_rr_arbiter_pkg.sv
// Shared AHB bus-matrix definitions: HTRANS/HBURST encodings and the burst
// length helper used by the output-stage arbiter.
package ahb_outstg_rr_arbiter_pkg;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] BRST_SINGLE = 3'b000;
  localparam logic [2:0] BRST_INCR   = 3'b001;
  localparam logic [2:0] BRST_WRAP4  = 3'b010;
  localparam logic [2:0] BRST_INCR4  = 3'b011;
  localparam logic [2:0] BRST_WRAP8  = 3'b100;
  localparam logic [2:0] BRST_INCR8  = 3'b101;
  localparam logic [2:0] BRST_WRAP16 = 3'b110;
  localparam logic [2:0] BRST_INCR16 = 3'b111;

  // Total beats of a fixed-length burst; 0 marks the undefined-length INCR.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      BRST_SINGLE:             burst_beats = 5'd1;
      BRST_WRAP4, BRST_INCR4:  burst_beats = 5'd4;
      BRST_WRAP8, BRST_INCR8:  burst_beats = 5'd8;
      BRST_WRAP16, BRST_INCR16: burst_beats = 5'd16;
      default:                 burst_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping,
// with 'last' itself considered at the end of the search.
module ahb_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic [PORT_W-1:0]    winner,
  output logic                 any_req
);

  logic [PORT_W-1:0] idx;

  // Scan from the farthest candidate down to the nearest so the nearest wins.
  always_comb begin
    winner  = last;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = PORT_W'((int'(last) + k) % NUM_PORTS);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_outstg_rr_arbiter.sv
// Round-robin arbiter for a bus-matrix output stage; keeps the address-phase
// owner through fixed bursts, INCR bursts, BUSY beats and locked sequences.
module ahb_outstg_rr_arbiter
  import ahb_outstg_rr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_W     = 2,
  parameter int RESET_PORT = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port
);

  logic [3:0]        beat_cnt;
  logic [3:0]        beat_cnt_nxt;
  logic [4:0]        beats;
  logic [PORT_W-1:0] last_port;
  logic [PORT_W-1:0] winner;
  logic              any_req;
  logic              hold;

  ahb_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req     (req_port),
    .last    (last_port),
    .winner  (winner),
    .any_req (any_req)
  );

  // A NONSEQ always restarts the count, which also covers early termination.
  always_comb begin
    beats        = burst_beats(HBURSTM);
    beat_cnt_nxt = beat_cnt;
    if (!HSELM || HTRANSM == TRN_IDLE) begin
      beat_cnt_nxt = 4'd0;
    end else if (HTRANSM == TRN_NONSEQ) begin
      beat_cnt_nxt = (beats == 5'd0) ? 4'd0 : 4'(beats - 5'd1);
    end else if (HTRANSM == TRN_SEQ && beat_cnt != 4'd0) begin
      beat_cnt_nxt = beat_cnt - 4'd1;
    end
  end

  assign hold = HMASTLOCKM
              | (HSELM & (beat_cnt_nxt != 4'd0))
              | (HSELM & (HBURSTM == BRST_INCR) & (HTRANSM != TRN_IDLE))
              | (HSELM & (HTRANSM == TRN_BUSY));

  // With no request the port index is kept so the data-phase register stays valid.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= PORT_W'(RESET_PORT);
      last_port    <= PORT_W'(RESET_PORT);
      no_port      <= 1'b1;
      beat_cnt     <= 4'd0;
    end else if (HREADYM) begin
      beat_cnt <= beat_cnt_nxt;
      if (!hold) begin
        if (any_req) begin
          addr_in_port <= winner;
          last_port    <= winner;
          no_port      <= 1'b0;
        end else begin
          no_port <= 1'b1;
        end
      end
    end
  end

  a_port_in_range: assert property (@(posedge HCLK) disable iff (!HRESETn)
    int'(addr_in_port) < NUM_PORTS);

endmodule

// File: tb/tb_ahb_outstg_rr_arbiter.sv
// Testbench for ahb_outstg_rr_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_ahb_outstg_rr_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] req_port;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;

  int checks = 0;
  int errors = 0;

  // Reference model: owner, round-robin pointer, idle flag, beats still owed.
  int m_owner, m_last, m_nop, m_beats;
  int len_tab [8] = '{1, 0, 4, 4, 8, 8, 16, 16};

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

  always #5 HCLK = ~HCLK;

  ahb_outstg_rr_arbiter #(
    .NUM_PORTS  (4),
    .PORT_W     (2),
    .RESET_PORT (0)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_port     (req_port),
    .HREADYM      (HREADYM),
    .HSELM        (HSELM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  task automatic model_reset();
    m_owner = 0;
    m_last  = 0;
    m_nop   = 1;
    m_beats = 0;
  endtask

  task automatic model_update(input logic [3:0] r, input logic rdy, input logic sel,
                              input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    int nb;
    bit keep;
    logic [1:0] p;
    if (!rdy) return;
    nb = m_beats;
    if (!sel || tr == IDLE) nb = 0;
    else if (tr == NSEQ) nb = (len_tab[bu] > 0) ? len_tab[bu] - 1 : 0;
    else if (tr == SEQ && nb > 0) nb = nb - 1;
    keep = lk || (sel && (nb != 0 || tr == BUSY || (bu == INCR && tr != IDLE)));
    m_beats = nb;
    if (!keep) begin
      m_nop = 1;
      for (int off = 1; off <= 4; off++) begin
        p = 2'((m_last + off) % 4);
        if (m_nop == 1 && r[p]) begin
          m_owner = int'(p);
          m_last  = int'(p);
          m_nop   = 0;
        end
      end
    end
  endtask

  // Drive one address-phase cycle, advance the model, sample 1 ns after the edge.
  task automatic step(input logic [3:0] r, input logic rdy, input logic sel,
                      input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    req_port   = r;
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = tr;
    HBURSTM    = bu;
    HMASTLOCKM = lk;
    model_update(r, rdy, sel, tr, bu, lk);
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    step(4'b0100, 1'b1, 1'b0, IDLE, SINGLE, 1'b0);
    model_reset();
    checks++;
    if (no_port !== 1'b1 || addr_in_port !== 2'd0 || dut.beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: addr=%0d no_port=%0b beat_cnt=%0d, expected 0/1/0",
               addr_in_port, no_port, dut.beat_cnt);
    end
    HRESETn = 1'b1;
    #1;
    checks++;
    if (no_port !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_port_after_release: no_port=%0b expected 1", no_port);
    end
    step(4'b0100, 1'b1, 1'b0, IDLE, SINGLE, 1'b0);
    checks++;
    if (addr_in_port !== 2'd2 || no_port !== 1'b0) begin
      errors++;
      $display("FAIL first_grant: addr=%0d no_port=%0b expected addr=2 no_port=0",
               addr_in_port, no_port);
    end
  endtask

  task automatic test_rotate();
    int exp_seq [5] = '{3, 0, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b1, NSEQ, SINGLE, 1'b0);
      checks++;
      if (int'(addr_in_port) != exp_seq[i] || no_port !== 1'b0) begin
        errors++;
        $display("FAIL rotate[%0d]: addr=%0d no_port=%0b expected addr=%0d no_port=0",
                 i, addr_in_port, no_port, exp_seq[i]);
      end
    end
  endtask

  task automatic test_incr4_stall_busy();
    step(4'b0010, 1'b1, 1'b1, NSEQ, SINGLE, 1'b0);
    checks++;
    if (addr_in_port !== 2'd1) begin
      errors++;
      $display("FAIL incr4_setup: addr=%0d expected 1", addr_in_port);
    end
    step(4'b1111, 1'b1, 1'b1, NSEQ, INCR4, 1'b0);
    checks++;
    if (addr_in_port !== 2'd1 || dut.beat_cnt !== 4'd3) begin
      errors++;
      $display("FAIL incr4_beat1: addr=%0d beat_cnt=%0d expected 1/3", addr_in_port, dut.beat_cnt);
    end
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1, SEQ, INCR4, 1'b0);
    step(4'b1111, 1'b1, 1'b1, SEQ, INCR4, 1'b0);
    step(4'b1111, 1'b1, 1'b1, SEQ, INCR4, 1'b0);
    step(4'b1111, 1'b1, 1'b1, BUSY, INCR4, 1'b0);
    checks++;
    if (addr_in_port !== 2'd1 || dut.beat_cnt !== 4'd1) begin
      errors++;
      $display("FAIL incr4_busy: addr=%0d beat_cnt=%0d expected 1/1", addr_in_port, dut.beat_cnt);
    end
    step(4'b1111, 1'b1, 1'b1, SEQ, INCR4, 1'b0);
    checks++;
    if (addr_in_port !== 2'd2 || dut.beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL incr4_end: addr=%0d beat_cnt=%0d expected 2/0", addr_in_port, dut.beat_cnt);
    end
  endtask

  task automatic test_lock();
    step(4'b0001, 1'b1, 1'b1, NSEQ, SINGLE, 1'b0);
    step(4'b1110, 1'b1, 1'b1, NSEQ, SINGLE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b1110, 1'b1, 1'b0, IDLE, SINGLE, 1'b1);
      checks++;
      if (addr_in_port !== 2'd0 || no_port !== 1'b0) begin
        errors++;
        $display("FAIL lock_gap[%0d]: addr=%0d no_port=%0b expected 0/0", i, addr_in_port, no_port);
      end
    end
    step(4'b1110, 1'b1, 1'b0, IDLE, SINGLE, 1'b0);
    checks++;
    if (addr_in_port !== 2'd1) begin
      errors++;
      $display("FAIL lock_release: addr=%0d expected 1", addr_in_port);
    end
  endtask

  task automatic test_early_term();
    step(4'b1111, 1'b1, 1'b1, NSEQ, INCR8, 1'b0);
    step(4'b1111, 1'b1, 1'b1, SEQ, INCR8, 1'b0);
    step(4'b1111, 1'b1, 1'b1, SEQ, INCR8, 1'b0);
    checks++;
    if (addr_in_port !== 2'd1 || dut.beat_cnt !== 4'd5) begin
      errors++;
      $display("FAIL incr8_3beats: addr=%0d beat_cnt=%0d expected 1/5", addr_in_port, dut.beat_cnt);
    end
    step(4'b1111, 1'b1, 1'b1, IDLE, INCR8, 1'b0);
    checks++;
    if (addr_in_port !== 2'd2 || dut.beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL incr8_idle_term: addr=%0d beat_cnt=%0d expected 2/0", addr_in_port, dut.beat_cnt);
    end
    step(4'b1111, 1'b1, 1'b1, NSEQ, INCR16, 1'b0);
    checks++;
    if (addr_in_port !== 2'd2 || dut.beat_cnt !== 4'd15) begin
      errors++;
      $display("FAIL incr16_load: addr=%0d beat_cnt=%0d expected 2/15", addr_in_port, dut.beat_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b1, SEQ, INCR16, 1'b0);
    checks++;
    if (dut.beat_cnt !== 4'd9 || addr_in_port !== 2'd2) begin
      errors++;
      $display("FAIL incr16_pre_reset: beat_cnt=%0d addr=%0d expected 9/2", dut.beat_cnt, addr_in_port);
    end
    HRESETn = 1'b0;
    #2;
    model_reset();
    checks++;
    if (no_port !== 1'b1 || addr_in_port !== 2'd0 || dut.beat_cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: addr=%0d no_port=%0b beat_cnt=%0d expected 0/1/0",
               addr_in_port, no_port, dut.beat_cnt);
    end
    HRESETn = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rdy, sel, lk;
    logic [1:0] tr;
    logic [2:0] bu;
    for (int i = 0; i < 600; i++) begin
      r   = 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      sel = ($urandom_range(0, 7) != 0);
      lk  = ($urandom_range(0, 11) == 0);
      tr  = 2'($urandom_range(0, 3));
      bu  = 3'($urandom_range(0, 7));
      step(r, rdy, sel, tr, bu, lk);
      checks++;
      if (int'(addr_in_port) != m_owner || int'(no_port) != m_nop || int'(dut.beat_cnt) != m_beats) begin
        errors++;
        $display("FAIL random[%0d]: addr=%0d no_port=%0b beat_cnt=%0d expected %0d/%0d/%0d",
                 i, addr_in_port, no_port, dut.beat_cnt, m_owner, m_nop, m_beats);
      end
    end
  endtask

  initial begin
    HRESETn    = 1'b0;
    req_port   = 4'b0000;
    HREADYM    = 1'b0;
    HSELM      = 1'b0;
    HTRANSM    = IDLE;
    HBURSTM    = SINGLE;
    HMASTLOCKM = 1'b0;
    model_reset();
    test_reset();
    test_rotate();
    test_incr4_stall_busy();
    test_lock();
    test_early_term();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
